des_key_schedule_seq: RTL and testbench
=======================================

// Module: des_key_schedule_seq
// PURPOSE
//  Sequential DES/3DES key schedule. Replaces the 16-way unrolled subkey generator with one PC-1 register pair and one shifter.
//  Streams one 48-bit subkey per accepted handshake, in encrypt (K1..Kn) or decrypt (Kn..K1) order.
//  Feeds the iterative round datapath; also provides byte-parity key checking.
// PARAMETERS
//  NUM_ROUNDS   16       subkeys per schedule, 1..16
//  SHIFT_SCHED  16'h7EFC bit i=1: round i rotates 2, else 1; only bits [NUM_ROUNDS-1:0] used
//  PARITY_CHK   1        1: check odd parity per key byte; 0: parity_err tied 0
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   reset, asynchronous, active-low
//  start        in   1   load key/decrypt and begin; honoured only while busy=0
//  key          in   64  DES key, key[63]=DES bit 1, parity bits at key[8k]
//  decrypt      in   1   0: ascending order, 1: descending order; sampled with start
//  abort        in   1   synchronous cancel of the running schedule
//  busy         out  1   schedule in progress
//  subkey_valid out  1   subkey/round_idx valid
//  subkey_ready in   1   consumer accepts the current subkey
//  subkey       out  48  PC-2 output, subkey[47]=PC-2 bit 1
//  round_idx    out  4   0-based round number of the presented subkey
//  done         out  1   1-cycle pulse after the last subkey is accepted
//  parity_err   out  1   latched at start: any key byte has even parity
// BEHAVIOUR
//  - Reset: IDLE; busy, subkey_valid, done, parity_err = 0; subkey, round_idx, C, D = 0.
//  - State machine: IDLE, GEN.
//  - IDLE, start=1 (cycle T):
//    - Load C, D from PC-1(key). Decrypt mode loads rot-left by TOTAL mod 28, TOTAL = sum of shifts.
//    - Latch mode and parity_err. Go to GEN.
//    - At T+1: busy=1, subkey_valid=1.
//  - Encrypt: C, D are rotated left by s[0] during the load cycle; subkey = PC-2(C,D), round_idx=0.
//    Each handshake (valid & ready) rotates left by s[r+1], r++.
//  - Decrypt: first subkey = PC-2 of the loaded C, D, round_idx=NUM_ROUNDS-1.
//    Each handshake rotates right by s[r], r--.
//  - Throughput: ready held high gives one subkey per cycle; NUM_ROUNDS cycles from first valid to last accept.
//  - Backpressure: while valid & !ready, subkey, round_idx, C, D and state hold.
//  - Last subkey (r=NUM_ROUNDS-1 encrypt, r=0 decrypt) accepted at cycle L:
//    - At L+1: valid=0, busy=0, done=1 for one cycle, state IDLE.
//    - A start at L+1 is accepted (busy=0), giving back-to-back keys.
//  - start while busy=1: ignored. key/decrypt changes while busy: no effect.
//  - abort in GEN:
//    - Next cycle: IDLE, valid=0, busy=0, no done pulse.
//    - abort outranks a coincident handshake. abort in IDLE: no effect.
//    - parity_err holds until the next start.
//  - Async reset mid-schedule: all outputs go to reset values immediately.
//  - Rotation is modulo 28 on each half; C and D always rotate together.
//  - subkey is registered (no comb path from key to subkey).
//  - round_idx is zero-extended; it never exceeds NUM_ROUNDS-1.
// TESTING
//  1. key=133457799BBCDFF1, decrypt=0, ready=1:
//     - first subkey 1B02EFFC7072, idx 0; 16th subkey CB3D8B0E17F5, idx 15.
//     - done exactly 1 cycle after the 16th accept; parity_err=0.
//  2. Same key, decrypt=1: first subkey CB3D8B0E17F5, idx 15; last 1B02EFFC7072, idx 0; full order is the reverse of test 1.
//  3. Random ready throttling, 3 keys back-to-back:
//     - stream is identical to the ready=1 run.
//     - subkey holds while ready=0; start accepted the cycle done=1.
//  4. key=123457799BBCDFF1 (byte 0x12 even): parity_err=1 from T+1; schedule still runs; cleared by the next start with a good key.
//  5. abort after idx 5 accepted: busy/valid=0 next cycle, no done; new start runs clean.
//     - rst_n low mid-stream: outputs zero asynchronously.
//  6. start asserted while busy: ignored, output stream unchanged.
//     - NUM_ROUNDS=4, SHIFT_SCHED=4'h0, decrypt=1: 4 subkeys matching reversed encrypt order.

Source files
------------

// File: rtl/des_key_schedule_seq.sv
// -----------------------------------------------------------------------------
// des_key_schedule_seq
//   Sequential DES/3DES key schedule. One PC-1 register pair (C, D) and one
//   rotator produce a single 48-bit PC-2 subkey per accepted handshake, in
//   encrypt (K1..Kn) or decrypt (Kn..K1) order. Also latches a byte-parity
//   check of the key at start.
//
// Parameters
//   NUM_ROUNDS   subkeys per schedule (1..16)
//   SHIFT_SCHED  bit i set: round i rotates by 2, otherwise by 1
//   PARITY_CHK   1: flag any key byte with even parity; 0: parity_err tied 0
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          load key/decrypt and begin (ignored while busy)
//   key[63:0]      DES key, key[63] = DES bit 1, parity bits at key[8k]
//   decrypt        0: ascending subkey order, 1: descending (sampled with start)
//   abort          synchronous cancel of a running schedule
//   busy           schedule in progress
//   subkey_valid   subkey/round_idx valid
//   subkey_ready   consumer accepts the presented subkey
//   subkey[47:0]   PC-2 output, subkey[47] = PC-2 bit 1
//   round_idx[3:0] 0-based round number of the presented subkey
//   done           one-cycle pulse after the last subkey is accepted
//   parity_err     latched at start: some key byte has even parity
// -----------------------------------------------------------------------------
module des_key_schedule_seq #(
  parameter int unsigned NUM_ROUNDS  = 16,
  parameter logic [15:0] SHIFT_SCHED = 16'h7EFC,
  parameter bit          PARITY_CHK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        abort,
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        done,
  output logic        parity_err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_GEN = 1'b1} state_t;

  localparam logic [3:0] LAST_IDX  = 4'(NUM_ROUNDS - 1);
  localparam logic [4:0] FIRST_AMT = SHIFT_SCHED[0] ? 5'd2 : 5'd1;

  // DES bit numbers (1 = key MSB) selected by PC-1: C half then D half
  localparam logic [6:0] PC1_TAB [56] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50,
    7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35,
    7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36, 7'd63, 7'd55,
    7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38,
    7'd30, 7'd22, 7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21,
    7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  // CD bit numbers (1 = C MSB) selected by PC-2
  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,
    6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,
    6'd27, 6'd20, 6'd13, 6'd2,  6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
    6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Total rotation of a full schedule, reduced modulo the half width.
  // Decrypt preloads C/D with this so the first subkey is the last round's.
  function automatic logic [4:0] total_mod();
    int unsigned t;
    t = 32'd0;
    for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
      t = t + (SHIFT_SCHED[i] ? 32'd2 : 32'd1);
    end
    return 5'(t % 32'd28);
  endfunction

  localparam logic [4:0] TOTAL_MOD = total_mod();

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [5:0]  idx;
    r = 56'd0;
    for (int i = 0; i < 56; i++) begin
      idx = 6'(7'd64 - PC1_TAB[i]);
      r   = {r[54:0], k[idx]};
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  idx;
    r = 48'd0;
    for (int i = 0; i < 48; i++) begin
      idx = 6'd56 - PC2_TAB[i];
      r   = {r[46:0], cd[idx]};
    end
    return r;
  endfunction

  // Left rotation of a 28-bit half by n (0..27); right rotation uses 28-n
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] n);
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction

  // Odd parity expected on every byte; an even-parity byte is an error
  function automatic logic key_parity_bad(input logic [63:0] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      bad = bad | ~(^k[8*b +: 8]);
    end
    return bad;
  endfunction

  state_t      r_state;
  logic        r_busy;
  logic        r_valid;
  logic        r_done;
  logic        r_parity_err;
  logic        r_decrypt;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [47:0] r_subkey;
  logic [3:0]  r_round_idx;

  logic [55:0] w_pc1;
  logic [4:0]  w_load_amt;
  logic [4:0]  w_step_amt;
  logic [3:0]  w_idx_inc;
  logic [27:0] w_load_c;
  logic [27:0] w_load_d;
  logic [27:0] w_step_c;
  logic [27:0] w_step_d;
  logic [47:0] w_load_sk;
  logic [47:0] w_step_sk;
  logic        w_last;
  logic        w_handshake;

  // Next C/D and subkey for both the load and the per-handshake step
  always_comb begin
    w_pc1     = pc1(key);
    w_idx_inc = r_round_idx + 4'd1;
    if (decrypt) begin
      w_load_amt = TOTAL_MOD;
    end else begin
      w_load_amt = FIRST_AMT;
    end
    // decrypt undoes round r's shift; encrypt applies round r+1's shift
    if (r_decrypt) begin
      w_step_amt = 5'd28 - (SHIFT_SCHED[r_round_idx] ? 5'd2 : 5'd1);
      w_last     = (r_round_idx == 4'd0);
    end else begin
      w_step_amt = SHIFT_SCHED[w_idx_inc] ? 5'd2 : 5'd1;
      w_last     = (r_round_idx == LAST_IDX);
    end
    w_load_c    = rotl28(w_pc1[55:28], w_load_amt);
    w_load_d    = rotl28(w_pc1[27:0],  w_load_amt);
    w_step_c    = rotl28(r_c, w_step_amt);
    w_step_d    = rotl28(r_d, w_step_amt);
    w_load_sk   = pc2({w_load_c, w_load_d});
    w_step_sk   = pc2({w_step_c, w_step_d});
    w_handshake = r_valid & subkey_ready;
  end

  // Schedule FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_parity_err <= 1'b0;
      r_decrypt    <= 1'b0;
      r_c          <= 28'd0;
      r_d          <= 28'd0;
      r_subkey     <= 48'd0;
      r_round_idx  <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_GEN;
            r_busy       <= 1'b1;
            r_valid      <= 1'b1;
            r_decrypt    <= decrypt;
            r_parity_err <= PARITY_CHK ? key_parity_bad(key) : 1'b0;
            r_c          <= w_load_c;
            r_d          <= w_load_d;
            r_subkey     <= w_load_sk;
            r_round_idx  <= decrypt ? LAST_IDX : 4'd0;
          end
        end
        ST_GEN: begin
          // abort wins over a handshake in the same cycle
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
          end else if (w_handshake) begin
            if (w_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_c      <= w_step_c;
              r_d      <= w_step_d;
              r_subkey <= w_step_sk;
              if (r_decrypt) begin
                r_round_idx <= r_round_idx - 4'd1;
              end else begin
                r_round_idx <= r_round_idx + 4'd1;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign subkey_valid = r_valid;
  assign subkey       = r_subkey;
  assign round_idx    = r_round_idx;
  assign done         = r_done;
  assign parity_err   = r_parity_err;

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// -----------------------------------------------------------------------------
// tb_des_key_schedule_seq
//   Two instances: u_a with the standard 16-round schedule, u_b with
//   NUM_ROUNDS=4 and SHIFT_SCHED=0. A textbook DES key-schedule model
//   (1-based bit arrays, bit-by-bit shifts) fills an expected-stream FIFO per
//   instance; one negedge process checks every output against it.
// -----------------------------------------------------------------------------
module tb_des_key_schedule_seq;

  localparam logic [63:0] TK = 64'h133457799BBCDFF1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_start, b_start;
  logic [63:0] key;
  logic        decrypt, abort, ready;
  logic        a_busy, a_valid, a_done, a_perr;
  logic [47:0] a_subkey;
  logic [3:0]  a_idx;
  logic        b_busy, b_valid, b_done, b_perr;
  logic [47:0] b_subkey;
  logic [3:0]  b_idx;

  always #5 clk = ~clk;

  des_key_schedule_seq u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .key(key), .decrypt(decrypt),
    .abort(abort), .busy(a_busy), .subkey_valid(a_valid), .subkey_ready(ready),
    .subkey(a_subkey), .round_idx(a_idx), .done(a_done), .parity_err(a_perr)
  );

  des_key_schedule_seq #(.NUM_ROUNDS(4), .SHIFT_SCHED(16'h0000), .PARITY_CHK(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .key(key), .decrypt(decrypt),
    .abort(abort), .busy(b_busy), .subkey_valid(b_valid), .subkey_ready(ready),
    .subkey(b_subkey), .round_idx(b_idx), .done(b_done), .parity_err(b_perr)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                     60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                     29,21,13,5,28,20,12,4};
  int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

  logic [47:0] mk [16];
  logic [47:0] exp_key  [2][256];
  logic [3:0]  exp_idx  [2][256];
  bit          exp_last [2][256];
  int          rd [2] = '{0, 0};
  int          wr [2] = '{0, 0};
  bit          done_nxt [2];
  bit          exp_par  [2];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Textbook key schedule: subkey of round r (0-based) into mk[r]
  task automatic gen_model(input logic [63:0] k, input int n, input logic [15:0] sch);
    bit kb [1:64];
    bit cb [1:28];
    bit db [1:28];
    bit cd [1:56];
    bit tc, td;
    logic [47:0] sk;
    for (int i = 1; i <= 64; i++) kb[i] = k[64-i];
    for (int i = 1; i <= 28; i++) begin
      cb[i] = kb[PC1_T[i-1]];
      db[i] = kb[PC1_T[i+27]];
    end
    for (int r = 0; r < 16; r++) mk[r] = '0;
    for (int r = 0; r < n; r++) begin
      for (int s = 0; s < (sch[r] ? 2 : 1); s++) begin
        tc = cb[1];
        td = db[1];
        for (int j = 1; j < 28; j++) begin
          cb[j] = cb[j+1];
          db[j] = db[j+1];
        end
        cb[28] = tc;
        db[28] = td;
      end
      for (int j = 1; j <= 28; j++) begin
        cd[j]    = cb[j];
        cd[j+28] = db[j];
      end
      sk = '0;
      for (int j = 0; j < 48; j++) sk = {sk[46:0], cd[PC2_T[j]]};
      mk[r] = sk;
    end
  endtask

  function automatic bit par_bad(input logic [63:0] k);
    for (int b = 0; b < 8; b++) begin
      if (($countones(k[8*b +: 8]) % 2) == 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic push(input int u, input logic [63:0] k, input logic dec);
    int n;
    int r;
    n = (u == 0) ? 16 : 4;
    gen_model(k, n, (u == 0) ? 16'h7EFC : 16'h0000);
    for (int i = 0; i < n; i++) begin
      r = dec ? (n - 1 - i) : i;
      exp_key[u][wr[u] % 256]  = mk[r];
      exp_idx[u][wr[u] % 256]  = 4'(r);
      exp_last[u][wr[u] % 256] = (i == n - 1);
      wr[u]++;
    end
    exp_par[u] = par_bad(k);
  endtask

  // Per-cycle check of one instance against its expected stream
  task automatic check_dut(input int u, input string p, input logic rst, input logic v,
                           input logic b, input logic d, input logic pe,
                           input logic [47:0] sk, input logic [3:0] ix,
                           input logic rdy, input logic ab);
    bit act;
    if (!rst) begin
      rd[u] = wr[u];
      done_nxt[u] = 1'b0;
      exp_par[u] = 1'b0;
      cmp({p, ".rst_valid"}, v, 0);
      cmp({p, ".rst_busy"}, b, 0);
      cmp({p, ".rst_done"}, d, 0);
      cmp({p, ".rst_parity"}, pe, 0);
      cmp({p, ".rst_subkey"}, sk, 0);
      cmp({p, ".rst_idx"}, ix, 0);
    end else begin
      act = (rd[u] != wr[u]);
      cmp({p, ".done"}, d, done_nxt[u]);
      done_nxt[u] = 1'b0;
      cmp({p, ".valid"}, v, act);
      cmp({p, ".busy"}, b, act);
      cmp({p, ".parity_err"}, pe, exp_par[u]);
      if (act && v) begin
        cmp({p, ".subkey"}, sk, exp_key[u][rd[u] % 256]);
        cmp({p, ".round_idx"}, ix, exp_idx[u][rd[u] % 256]);
        if (ab) begin
          rd[u] = wr[u];
        end else if (rdy) begin
          if (exp_last[u][rd[u] % 256]) done_nxt[u] = 1'b1;
          rd[u]++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, "A", rst_n, a_valid, a_busy, a_done, a_perr, a_subkey, a_idx, ready, abort);
    check_dut(1, "B", rst_n, b_valid, b_busy, b_done, b_perr, b_subkey, b_idx, ready, abort);
  end

  // Called at posedge+1 with the target idle; returns at posedge+1 after acceptance
  task automatic start_dut(input int u, input logic [63:0] k, input logic dec);
    key = k;
    decrypt = dec;
    if (u == 0) a_start = 1'b1;
    else        b_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    b_start = 1'b0;
    push(u, k, dec);
    key = {$urandom, $urandom};
    decrypt = ~dec;
    cmp("busy_after_start", (u == 0) ? a_busy : b_busy, 1);
  endtask

  task automatic wait_done(input int u, input int max);
    int c;
    bit got;
    c = 0;
    got = 1'b0;
    while (!got && c < max) begin
      @(posedge clk); #1;
      c++;
      got = (u == 0) ? a_done : b_done;
    end
    cmp("wait_done", got, 1);
  endtask

  logic [63:0] t3_keys [3] = '{64'h133457799BBCDFF1, 64'h0E329232EA6D0D73, 64'h0123456789ABCDEF};
  logic        t3_dec  [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int c;
    bit got;
    rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
    key = '0; decrypt = 1'b0; abort = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // model pinned to hand-known subkeys
    gen_model(TK, 16, 16'h7EFC);
    cmp("model_K1", mk[0], 48'h1B02EFFC7072);
    cmp("model_K16", mk[15], 48'hCB3D8B0E17F5);
    gen_model(TK, 4, 16'h0000);
    cmp("model4_r0", mk[0], 48'h1B02EFFC7072);
    cmp("model4_r1", mk[1], 48'h79AED9DBC9E5);
    @(posedge clk); #1;

    // 1: encrypt, ready held high
    start_dut(0, TK, 1'b0);
    cmp("t1_first_subkey", a_subkey, 48'h1B02EFFC7072);
    cmp("t1_first_idx", a_idx, 0);
    cmp("t1_parity", a_perr, 0);
    repeat (15) @(posedge clk); #1;
    cmp("t1_last_subkey", a_subkey, 48'hCB3D8B0E17F5);
    cmp("t1_last_idx", a_idx, 15);
    cmp("t1_no_early_done", a_done, 0);
    @(posedge clk); #1;
    cmp("t1_done", a_done, 1);
    cmp("t1_busy_low", a_busy, 0);
    @(posedge clk); #1;
    cmp("t1_done_one_cycle", a_done, 0);

    // 2: decrypt order
    start_dut(0, TK, 1'b1);
    cmp("t2_first_subkey", a_subkey, 48'hCB3D8B0E17F5);
    cmp("t2_first_idx", a_idx, 15);
    repeat (15) @(posedge clk); #1;
    cmp("t2_last_subkey", a_subkey, 48'h1B02EFFC7072);
    cmp("t2_last_idx", a_idx, 0);
    @(posedge clk); #1;
    cmp("t2_done", a_done, 1);
    @(posedge clk); #1;

    // 3: random throttling, back-to-back keys started in the done cycle
    for (int k = 0; k < 3; k++) begin
      start_dut(0, t3_keys[k], t3_dec[k]);
      c = 0;
      got = 1'b0;
      while (!got && c < 300) begin
        ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        c++;
        got = a_done;
      end
      cmp("t3_done_reached", got, 1);
    end
    ready = 1'b1;

    // 4: even-parity byte flagged, schedule still runs, cleared by next start
    start_dut(0, 64'h123457799BBCDFF1, 1'b0);
    cmp("t4_parity_err", a_perr, 1);
    wait_done(0, 40);
    start_dut(0, TK, 1'b0);
    cmp("t4_parity_cleared", a_perr, 0);
    wait_done(0, 40);

    // 5: abort in idle is harmless; abort after idx 5 accepted
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    cmp("t5_idle_abort", a_busy, 0);
    start_dut(0, 64'h0E329232EA6D0D73, 1'b0);
    c = 0;
    while (a_idx != 4'd6 && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    cmp("t5_reach_idx6", a_idx, 6);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    cmp("t5_abort_busy", a_busy, 0);
    cmp("t5_abort_valid", a_valid, 0);
    cmp("t5_abort_no_done", a_done, 0);
    @(posedge clk); #1;
    cmp("t5_still_no_done", a_done, 0);
    start_dut(0, TK, 1'b0);
    wait_done(0, 40);

    // 5b: asynchronous reset mid-stream
    start_dut(0, 64'h123457799BBCDFF1, 1'b1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("t5_async_busy", a_busy, 0);
    cmp("t5_async_valid", a_valid, 0);
    cmp("t5_async_subkey", a_subkey, 0);
    cmp("t5_async_idx", a_idx, 0);
    cmp("t5_async_parity", a_perr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_dut(0, TK, 1'b0);
    wait_done(0, 40);

    // 6: start while busy is ignored
    start_dut(0, 64'h0E329232EA6D0D73, 1'b1);
    repeat (3) @(posedge clk); #1;
    key = TK;
    decrypt = 1'b0;
    a_start = 1'b1;
    repeat (2) @(posedge clk); #1;
    a_start = 1'b0;
    wait_done(0, 40);
    @(posedge clk); #1;
    cmp("t6_idle_after", a_busy, 0);

    // 6b: 4-round, all-single-shift schedule, both orders
    start_dut(1, TK, 1'b0);
    cmp("t6b_enc_first", b_subkey, 48'h1B02EFFC7072);
    wait_done(1, 20);
    start_dut(1, TK, 1'b1);
    cmp("t6b_dec_first_idx", b_idx, 3);
    repeat (3) @(posedge clk); #1;
    cmp("t6b_dec_last_subkey", b_subkey, 48'h1B02EFFC7072);
    cmp("t6b_dec_last_idx", b_idx, 0);
    @(posedge clk); #1;
    cmp("t6b_done", b_done, 1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
